// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch / next-PC sequencer: FSM encoding,
// MIPS opcode constants and the reset PC default.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [5:0] OP_R_FORMAT = 6'h00;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_J        = 6'h02;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sign-extended word offset of a branch immediate, in bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bus: instruction-memory handshake plus the decode/retire
// side. master = fetch unit, slave = memory and datapath.
interface fetch_pc_unit_if #(
    parameter int CNT_W = 32
) ();
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_valid;
    logic [31:0]      imem_rdata;
    logic [31:0]      inst;
    logic             inst_valid;
    logic [31:0]      pc_plus4;
    logic             retire;
    logic             Branch;
    logic             Jump;
    logic             Beq;
    logic             zero;
    logic             gtz;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output imem_req, imem_addr, inst, inst_valid, pc_plus4, retired_cnt,
        input  imem_valid, imem_rdata, retire, Branch, Jump, Beq, zero, gtz
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_valid, pc_plus4, retired_cnt,
        output imem_valid, imem_rdata, retire, Branch, Jump, Beq, zero, gtz
    );
endinterface

// File: rtl/fetch_pc_unit_next_pc_logic.sv
// Combinational next-PC resolution: sequential, conditional branch or jump,
// with jump taking priority. Kept standalone for reuse by a pipelined fetch.
module next_pc_logic
    import fetch_pc_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] target_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        beq_i,
    input  logic        zero_i,
    input  logic        gtz_i,
    output logic [31:0] next_pc_o
);
    logic [31:0] seq_pc;
    logic [31:0] btgt;
    logic [31:0] jtgt;

    assign seq_pc = pc_i + 32'd4;
    assign btgt   = seq_pc + branch_offset(target_i[15:0]);
    assign jtgt   = {seq_pc[31:28], target_i, 2'b00};

    // Undriven/unknown controls fail every if-test and fall through to seq_pc.
    always_comb begin
        next_pc_o = seq_pc;
        if (jump_i) begin
            next_pc_o = jtgt;
        end else if (branch_i && beq_i && zero_i) begin
            next_pc_o = btgt;
        end else if (branch_i && !beq_i && gtz_i) begin
            next_pc_o = btgt;
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch / next-PC sequencer: owns the PC, fetches over a
// req/valid handshake, holds the word for decode and advances on retire.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_unit_if.master bus
);
    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      next_pc;

    next_pc_logic u_next_pc (
        .pc_i      (pc_q),
        .target_i  (inst_q[25:0]),
        .branch_i  (bus.Branch),
        .jump_i    (bus.Jump),
        .beq_i     (bus.Beq),
        .zero_i    (bus.zero),
        .gtz_i     (bus.gtz),
        .next_pc_o (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (bus.imem_valid) begin
                    inst_d  = bus.imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.retire) begin
                    pc_d    = next_pc;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = {pc_q[31:2], 2'b00};
    assign bus.inst        = inst_q;
    assign bus.inst_valid  = (state_q == HOLD);
    assign bus.pc_plus4    = pc_q + 32'd4;
    assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, BEQ/BGTZ/J resolution,
// handshake stalls and spurious strobes, mid-fetch reset and PC wrap.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if bus_a ();
    fetch_pc_unit_if bus_h ();

    fetch_pc_unit dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fetch_pc_unit #(.RESET_PC(32'h8000_0040)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));

    localparam logic [31:0] W_RTYPE = {OP_R_FORMAT, 26'h12A_4020};
    localparam logic [31:0] W_BEQ_M4 = {OP_BEQ, 5'd1, 5'd2, 16'hFFFC};
    localparam logic [31:0] W_BEQ_M2 = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
    localparam logic [31:0] W_BGTZ_3 = {OP_BGTZ, 5'd1, 5'd0, 16'h0003};
    localparam logic [31:0] W_J_10 = {OP_J, 26'h000_0004};
    localparam logic [31:0] W_J_20 = {OP_J, 26'h000_0008};
    localparam logic [31:0] W_J_48 = {OP_J, 26'h000_0012};
    localparam logic [31:0] W_J_HI = {OP_J, 26'h000_0100};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.imem_valid = 0; bus_a.imem_rdata = '0; bus_a.retire = 0;
        bus_a.Branch = 0; bus_a.Jump = 0; bus_a.Beq = 0; bus_a.zero = 0; bus_a.gtz = 0;
        bus_h.imem_valid = 0; bus_h.imem_rdata = '0; bus_h.retire = 0;
        bus_h.Branch = 0; bus_h.Jump = 0; bus_h.Beq = 0; bus_h.zero = 0; bus_h.gtz = 0;
    endtask

    // Waits (bounded) for a request, then returns the word with zero wait.
    task automatic serve(input bit sel, input logic [31:0] word, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((sel ? bus_h.imem_req : bus_a.imem_req) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            if (sel) begin bus_h.imem_valid = 1; bus_h.imem_rdata = word; end
            else     begin bus_a.imem_valid = 1; bus_a.imem_rdata = word; end
            tick();
            idle_inputs();
        end
    endtask

    task automatic retire_ctl(input bit sel, input logic b, j, q, z, g);
        if (sel) begin
            bus_h.retire = 1; bus_h.Branch = b; bus_h.Jump = j; bus_h.Beq = q; bus_h.zero = z; bus_h.gtz = g;
        end else begin
            bus_a.retire = 1; bus_a.Branch = b; bus_a.Jump = j; bus_a.Beq = q; bus_a.zero = z; bus_a.gtz = g;
        end
        tick();
        idle_inputs();
    endtask

    task automatic run_instr(input bit sel, input logic [31:0] word, input logic b, j, q, z, g,
                             output bit ok);
        serve(sel, word, ok);
        if (ok) retire_ctl(sel, b, j, q, z, g);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_a.imem_req !== 1'b0 || bus_a.inst_valid !== 1'b0 || bus_a.inst !== 32'h0)
            begin errors++; $display("FAIL reset_ctl req=%b iv=%b inst=%h exp 0 0 0", bus_a.imem_req, bus_a.inst_valid, bus_a.inst); end
        checks++;
        if (bus_a.retired_cnt !== 32'd0 || bus_a.pc_plus4 !== 32'h4 || bus_a.imem_addr !== 32'h0)
            begin errors++; $display("FAIL reset_pc cnt=%0d pc4=%h addr=%h exp 0 4 0", bus_a.retired_cnt, bus_a.pc_plus4, bus_a.imem_addr); end
        checks++;
        if (bus_h.imem_addr !== 32'h8000_0040 || bus_h.pc_plus4 !== 32'h8000_0044)
            begin errors++; $display("FAIL reset_hi addr=%h pc4=%h exp 80000040 80000044", bus_h.imem_addr, bus_h.pc_plus4); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        bit ok;
        checks++;
        if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h0)
            begin errors++; $display("FAIL seq_first req=%b addr=%h exp 1 0", bus_a.imem_req, bus_a.imem_addr); end
        serve(0, W_RTYPE, ok);
        checks++;
        if (!ok || bus_a.inst_valid !== 1'b1 || bus_a.inst !== W_RTYPE || bus_a.imem_req !== 1'b0 || bus_a.pc_plus4 !== 32'h4)
            begin errors++; $display("FAIL seq_hold ok=%b iv=%b inst=%h req=%b pc4=%h exp 1 1 %h 0 4", ok, bus_a.inst_valid, bus_a.inst, bus_a.imem_req, bus_a.pc_plus4, W_RTYPE); end
        retire_ctl(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h4 || bus_a.inst_valid !== 1'b0)
            begin errors++; $display("FAIL seq_addr4 req=%b addr=%h iv=%b exp 1 4 0", bus_a.imem_req, bus_a.imem_addr, bus_a.inst_valid); end
        run_instr(0, W_RTYPE, 0, 0, 0, 0, 0, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'h8)
            begin errors++; $display("FAIL seq_addr8 ok=%b addr=%h exp 8", ok, bus_a.imem_addr); end
        run_instr(0, W_RTYPE, 0, 0, 0, 0, 0, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'hC || bus_a.retired_cnt !== 32'd3)
            begin errors++; $display("FAIL seq_addrC ok=%b addr=%h cnt=%0d exp C 3", ok, bus_a.imem_addr, bus_a.retired_cnt); end
    endtask

    task automatic test_beq();
        bit ok;
        run_instr(0, W_RTYPE, 0, 0, 0, 0, 0, ok);
        run_instr(0, W_BEQ_M4, 1, 0, 1, 1, 0, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'h4)
            begin errors++; $display("FAIL beq_taken ok=%b addr=%h exp 4", ok, bus_a.imem_addr); end
        run_instr(0, W_J_10, 1, 1, 0, 0, 0, ok);
        run_instr(0, W_BEQ_M4, 1, 0, 1, 0, 0, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'h14 || bus_a.retired_cnt !== 32'd7)
            begin errors++; $display("FAIL beq_not_taken ok=%b addr=%h cnt=%0d exp 14 7", ok, bus_a.imem_addr, bus_a.retired_cnt); end
    endtask

    task automatic test_bgtz();
        bit ok;
        run_instr(0, W_J_20, 1, 1, 0, 0, 0, ok);
        run_instr(0, W_BGTZ_3, 1, 0, 0, 0, 1, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'h30)
            begin errors++; $display("FAIL bgtz_taken ok=%b addr=%h exp 30", ok, bus_a.imem_addr); end
        run_instr(0, W_J_20, 1, 1, 0, 0, 0, ok);
        run_instr(0, W_BGTZ_3, 1, 0, 0, 0, 0, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'h24)
            begin errors++; $display("FAIL bgtz_not_taken ok=%b addr=%h exp 24", ok, bus_a.imem_addr); end
        run_instr(0, W_J_20, 1, 1, 0, 0, 0, ok);
        run_instr(0, W_BGTZ_3, 1, 0, 0, 1, 0, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'h24)
            begin errors++; $display("FAIL bgtz_zero_ignored ok=%b addr=%h exp 24", ok, bus_a.imem_addr); end
        run_instr(0, W_BEQ_M4, 1, 0, 1, 0, 1, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'h28 || bus_a.retired_cnt !== 32'd14)
            begin errors++; $display("FAIL beq_gtz_ignored ok=%b addr=%h cnt=%0d exp 28 14", ok, bus_a.imem_addr, bus_a.retired_cnt); end
    endtask

    task automatic test_jump_priority();
        bit ok;
        run_instr(1, W_J_HI, 1, 1, 1, 1, 1, ok);
        checks++;
        if (!ok || bus_h.imem_req !== 1'b1 || bus_h.imem_addr !== 32'h8000_0400 || bus_h.retired_cnt !== 32'd1)
            begin errors++; $display("FAIL jump_priority ok=%b addr=%h cnt=%0d exp 80000400 1", ok, bus_h.imem_addr, bus_h.retired_cnt); end
    endtask

    task automatic test_stall_spurious();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin bus_a.retire = 1; bus_a.Jump = 1; bus_a.Branch = 1; end
            tick();
            idle_inputs();
            checks++;
            if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h28 || bus_a.retired_cnt !== 32'd14)
                begin errors++; $display("FAIL stall_cycle%0d req=%b addr=%h cnt=%0d exp 1 28 14", i, bus_a.imem_req, bus_a.imem_addr, bus_a.retired_cnt); end
        end
        serve(0, W_RTYPE, ok);
        bus_a.imem_valid = 1; bus_a.imem_rdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        checks++;
        if (!ok || bus_a.inst !== W_RTYPE || bus_a.inst_valid !== 1'b1 || bus_a.imem_req !== 1'b0)
            begin errors++; $display("FAIL spurious_valid ok=%b inst=%h iv=%b req=%b exp %h 1 0", ok, bus_a.inst, bus_a.inst_valid, bus_a.imem_req, W_RTYPE); end
        bus_a.retire = 1; bus_a.imem_valid = 1; bus_a.imem_rdata = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        checks++;
        if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h2C || bus_a.inst_valid !== 1'b0 || bus_a.retired_cnt !== 32'd15)
            begin errors++; $display("FAIL valid_and_retire req=%b addr=%h iv=%b cnt=%0d exp 1 2C 0 15", bus_a.imem_req, bus_a.imem_addr, bus_a.inst_valid, bus_a.retired_cnt); end
    endtask

    task automatic test_reset_and_wrap();
        bit ok;
        run_instr(0, W_J_48, 1, 1, 0, 0, 0, ok);
        tick();
        checks++;
        if (!ok || bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h48)
            begin errors++; $display("FAIL pre_reset ok=%b req=%b addr=%h exp 1 48", ok, bus_a.imem_req, bus_a.imem_addr); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus_a.imem_req !== 1'b0 || bus_a.inst_valid !== 1'b0 || bus_a.inst !== 32'h0 || bus_a.retired_cnt !== 32'd0 ||
            bus_a.pc_plus4 !== 32'h4 || bus_a.imem_addr !== 32'h0)
            begin errors++; $display("FAIL mid_fetch_reset req=%b iv=%b inst=%h cnt=%0d pc4=%h addr=%h", bus_a.imem_req, bus_a.inst_valid, bus_a.inst, bus_a.retired_cnt, bus_a.pc_plus4, bus_a.imem_addr); end
        rst = 1'b1;
        tick();
        checks++;
        if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h0)
            begin errors++; $display("FAIL refetch req=%b addr=%h exp 1 0", bus_a.imem_req, bus_a.imem_addr); end
        run_instr(0, W_BEQ_M2, 1, 0, 1, 1, 0, ok);
        checks++;
        if (!ok || bus_a.imem_addr !== 32'hFFFF_FFFC)
            begin errors++; $display("FAIL branch_back ok=%b addr=%h exp FFFFFFFC", ok, bus_a.imem_addr); end
        serve(0, W_RTYPE, ok);
        checks++;
        if (!ok || bus_a.pc_plus4 !== 32'h0)
            begin errors++; $display("FAIL wrap_pc4 ok=%b pc4=%h exp 0", ok, bus_a.pc_plus4); end
        retire_ctl(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus_a.imem_addr !== 32'h0 || bus_a.retired_cnt !== 32'd2)
            begin errors++; $display("FAIL wrap_addr addr=%h cnt=%0d exp 0 2", bus_a.imem_addr, bus_a.retired_cnt); end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_beq();
        test_bgtz();
        test_jump_priority();
        test_stall_spurious();
        test_reset_and_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
